// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use a shift-add loop, DIV/DIVU a restoring shift-subtract loop;
// both run on operand magnitudes, and the sign is applied on the last step.
// Handshake: start is sampled only in IDLE; busy is high while iterating;
// done pulses for one cycle once HI/LO hold the new result. MTHI/MTLO writes
// are accepted only in IDLE when start is low.
module mult_div_unit #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] rdat1,
    input  logic [WORD_W-1:0] rdat2,
    input  logic              hi_wen,
    input  logic              lo_wen,
    input  logic [WORD_W-1:0] wdat,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(WORD_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  is_div_q;   // divide (1) or multiply (0)
    logic                  neg_q;      // product / quotient is negative
    logic                  rem_neg_q;  // remainder is negative
    logic                  divz_q;     // divisor was zero at start
    logic [WORD_W-1:0]     m_q;        // multiplicand or divisor magnitude
    logic [2*WORD_W-1:0]   acc_q;      // {upper, lower} working register
    logic [CNT_W-1:0]      cnt_q;

    // Operand sign handling at start
    logic              a_neg, b_neg;
    logic [WORD_W-1:0] a_mag, b_mag;

    // One iteration step
    logic [WORD_W:0]     mul_sum;
    logic [2*WORD_W-1:0] mul_next;
    logic [WORD_W:0]     div_shift;
    logic                div_ge;
    logic [WORD_W-1:0]   div_diff;
    logic [2*WORD_W-1:0] div_next;
    logic [2*WORD_W-1:0] step_next;
    logic [2*WORD_W-1:0] prod_fix;
    logic [WORD_W-1:0]   fin_hi, fin_lo;

    // Operand magnitudes and the per-iteration datapath step
    always_comb begin
        a_neg     = op[0] & rdat1[WORD_W-1];
        b_neg     = op[0] & rdat2[WORD_W-1];
        a_mag     = a_neg ? -rdat1 : rdat1;
        b_mag     = b_neg ? -rdat2 : rdat2;

        // Multiply: add multiplicand into the upper half when LSB set, shift right
        mul_sum   = {1'b0, acc_q[2*WORD_W-1:WORD_W]} + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_next  = {mul_sum, acc_q[WORD_W-1:1]};

        // Divide: shift next dividend bit into remainder, subtract if it fits
        div_shift = {acc_q[2*WORD_W-1:WORD_W], acc_q[WORD_W-1]};
        div_ge    = div_shift >= {1'b0, m_q};
        div_diff  = div_shift[WORD_W-1:0] - m_q;
        div_next  = {(div_ge ? div_diff : div_shift[WORD_W-1:0]),
                     acc_q[WORD_W-2:0], div_ge};

        step_next = is_div_q ? div_next : mul_next;

        // Sign correction applied to the final step's value
        prod_fix  = neg_q ? -step_next : step_next;
        if (is_div_q) begin
            fin_lo = neg_q ? -step_next[WORD_W-1:0] : step_next[WORD_W-1:0];
            fin_hi = rem_neg_q ? -step_next[2*WORD_W-1:WORD_W]
                               : step_next[2*WORD_W-1:WORD_W];
        end else begin
            fin_lo = prod_fix[WORD_W-1:0];
            fin_hi = prod_fix[2*WORD_W-1:WORD_W];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (nrst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_CALC;
            S_CALC: if (divz_q || cnt_q == LAST_ITER) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, iteration, result write-back and MTHI/MTLO
    always_ff @(posedge clk) begin
        if (nrst) begin
            hi        <= '0;
            lo        <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            divz_q    <= 1'b0;
            m_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        divz_q    <= op[1] && (rdat2 == '0);
                        cnt_q     <= '0;
                        if (op[1]) begin
                            m_q <= b_mag;
                            // Divide-by-zero result is preloaded and written after one CALC cycle
                            acc_q <= (rdat2 == '0) ? {rdat1, {WORD_W{1'b1}}}
                                                   : {{WORD_W{1'b0}}, a_mag};
                        end else begin
                            m_q   <= a_mag;
                            acc_q <= {{WORD_W{1'b0}}, b_mag};
                        end
                    end else begin
                        if (hi_wen) hi <= wdat;
                        if (lo_wen) lo <= wdat;
                    end
                end
                S_CALC: begin
                    if (divz_q) begin
                        hi <= acc_q[2*WORD_W-1:WORD_W];
                        lo <= acc_q[WORD_W-1:0];
                    end else begin
                        acc_q <= step_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) begin
                            hi <= fin_hi;
                            lo <= fin_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q == S_CALC);
    assign done      = (state_q == S_DONE);
    assign div_zero  = done & divz_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vector table, hand-written corner
// sequences (ignored start/MTHI while busy, MTLO, reset abort) and random
// operations checked against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rdat1, rdat2, wdat;
    logic         hi_wen, lo_wen;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dz;
    } vec_t;

    vec_t vecs[10];

    mult_div_unit #(.WORD_W(W)) dut (
        .clk(clk), .nrst(nrst), .start(start), .op(op),
        .rdat1(rdat1), .rdat2(rdat2), .hi_wen(hi_wen), .lo_wen(lo_wen),
        .wdat(wdat), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; returns {div_zero, hi, lo}
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [2*W-1:0] p;
        case (o)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'b01: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                return {1'b0, p};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    sa = longint'({32'b0, a});
                    sb = longint'({32'b0, b});
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[W-1:0], q[W-1:0]};
            end
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        nrst = 1'b0;
    endtask

    // Issue one start pulse; operands are scrambled afterwards
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op = o; rdat1 = a; rdat2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rdat1 = $urandom;
        rdat2 = $urandom;
    endtask

    // Wait (bounded) for done; check latency and busy length.
    // Called at the first negedge after the start edge.
    task automatic wait_done(input string name, input int exp_lat);
        int lat = 1;
        int busy_cnt = 0;
        while (!done && lat < 80) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        chk({name, " done_seen"}, 32'(done), 32'd1);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    endtask

    // Run one operation and score it against an expected result
    task automatic run_check(input string name, input logic [1:0] o, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] e_hi,
                             input logic [W-1:0] e_lo, input logic e_dz);
        logic is_dz;
        is_dz = o[1] && (b == 0);
        exp_q.push_back(e_hi);
        exp_q.push_back(e_lo);
        issue(o, a, b);
        wait_done(name, is_dz ? 2 : 33);
        chk({name, " hi"}, hi, exp_q.pop_front());
        chk({name, " lo"}, lo, exp_q.pop_front());
        chk({name, " div_zero"}, 32'(div_zero), 32'(e_dz));
        chk({name, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({name, " done_pulse_len"}, 32'(done), 32'd0);
        chk({name, " div_zero_after"}, 32'(div_zero), 32'd0);
    endtask

    initial begin
        logic [2*W:0] m;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[7] = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[8] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[9] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};

        nrst = 1'b1; start = 1'b0; op = 2'b00; rdat1 = '0; rdat2 = '0;
        hi_wen = 1'b0; lo_wen = 1'b0; wdat = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);

        // reset state
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset div_zero", 32'(div_zero), 32'd0);
        chk("reset state", 32'(state_dbg), 32'd0);

        // directed vector table
        for (int i = 0; i < 10; i++)
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz);

        // start and MTHI during busy are ignored; result DIVU 100/7
        issue(2'b10, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b00; rdat1 = 32'd9; rdat2 = 32'd9;
        hi_wen = 1'b1; wdat = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_wen = 1'b0;
        wait_done("ignore", 29);
        chk("ignore hi", hi, 32'd2);
        chk("ignore lo", lo, 32'd14);
        @(negedge clk);
        chk("ignore back_idle", 32'(state_dbg), 32'd0);
        chk("ignore no_restart", 32'(busy), 32'd0);

        // MTLO in IDLE
        lo_wen = 1'b1; wdat = 32'h1234_5678;
        @(negedge clk);
        lo_wen = 1'b0;
        chk("mtlo lo", lo, 32'h1234_5678);
        chk("mtlo hi_kept", hi, 32'd2);

        // MTHI+MTLO together
        hi_wen = 1'b1; lo_wen = 1'b1; wdat = 32'hA5A5_0F0F;
        @(negedge clk);
        hi_wen = 1'b0; lo_wen = 1'b0;
        chk("mthilo hi", hi, 32'hA5A5_0F0F);
        chk("mthilo lo", lo, 32'hA5A5_0F0F);

        // start wins over hi_wen in the same cycle
        @(negedge clk);
        op = 2'b00; rdat1 = 32'd3; rdat2 = 32'd4; start = 1'b1;
        hi_wen = 1'b1; wdat = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0; hi_wen = 1'b0;
        chk("startwins hi_unwritten", hi, 32'hA5A5_0F0F);
        wait_done("startwins", 33);
        chk("startwins hi", hi, 32'd0);
        chk("startwins lo", lo, 32'd12);
        @(negedge clk);

        // reset mid-operation aborts
        issue(2'b00, 32'h0001_0000, 32'h0001_0000);
        repeat (9) @(negedge clk);
        do_reset();
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hi", hi, 32'h0);
        chk("abort lo", lo, 32'h0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (done || busy) seen++;
                @(negedge clk);
            end
            chk("abort no_done", 32'(seen), 32'd0);
        end
        run_check("after_abort", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            m = model(ro, ra, rb);
            run_check($sformatf("rand%0d", i), ro, ra, rb, m[2*W-1:W], m[W-1:0], m[2*W]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global time limit
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: got no finish expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes register read data rdat1/rdat2 as operands and produces results into dedicated HI/LO registers, read back for MFHI/MFLO.
- Uses a start/busy/done handshake so the control unit can stall the pipeline while an operation runs.
- Also supports direct HI/LO writes (MTHI/MTLO).

Parameters:
- WORD_W, 32, operand/result width; iteration count equals WORD_W.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  synchronous reset, active-high (asserted when 1). The name is kept uniform across the datapath.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rdat1  in  WORD_W  operand A (multiplicand/dividend).
- rdat2  in  WORD_W  operand B (multiplier/divisor).
- hi_wen  in  1  MTHI strobe.
- lo_wen  in  1  MTLO strobe.
- wdat  in  WORD_W  MTHI/MTLO data.
- busy  out  1  operation in progress; control stalls on busy.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  divide-by-zero indicator, valid with done.
- hi  out  WORD_W  HI register (product upper word / remainder).
- lo  out  WORD_W  LO register (product lower word / quotient).

Behaviour:
- Reset (nrst=1 at a rising edge):
  - state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0.
  - Reset mid-operation aborts the operation; no partial result reaches HI/LO.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at edge E0:
  - Latch op, rdat1, rdat2.
  - Signed ops store operand magnitudes and record the result sign (product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA).
  - Clear iteration counter; go to CALC.
- IDLE, start=0: stay in IDLE.
- CALC:
  - Each edge performs one shift-add (multiply) or restoring shift-subtract (divide) step; counter increments.
  - On edge E0+WORD_W (the 32nd iteration): apply sign correction (two's-complement negate where the sign is negative), write hi/lo, go to DONE.
  - busy=1 exactly while state==CALC.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE. busy=0 in DONE.
- Latency: done is high in the cycle after edge E0+32; a back-to-back start may be accepted at the edge leaving DONE+1, i.e. once in IDLE.
- start while CALC or DONE: ignored; operands are not re-sampled.
- Divide by zero (DIV/DIVU with rdat2==0 at E0):
  - No iterations. E0 goes to a single CALC cycle, then the next edge writes hi=rdat1, lo=0xFFFFFFFF and enters DONE.
  - div_zero=1 while done=1; otherwise div_zero=0.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000 (a natural result of the magnitude algorithm); no flag.
- MTHI/MTLO:
  - hi_wen/lo_wen write hi/lo from wdat at the edge, only in IDLE and only when start=0.
  - Ignored in CALC/DONE, and ignored when start=1 in the same cycle (start wins).
  - hi_wen and lo_wen together write both registers with wdat.
- hi/lo hold their values in all other cases. Operand inputs may change freely after E0.
- Full width: 64-bit product computed internally; hi=bits[63:32], lo=bits[31:0].

Test Plan:
- Reset, then MULTU rdat1=0xFFFFFFFF, rdat2=0xFFFFFFFF, start 1 cycle -> busy=1 for 32 cycles, done pulse once, hi=0xFFFFFFFE, lo=0x00000001.
- MULT rdat1=0xFFFFFFFD (-3), rdat2=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15), div_zero=0.
- DIV rdat1=0xFFFFFFF9 (-7), rdat2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rdat1=5, rdat2=0 -> done two cycles after start edge, div_zero=1 with done, hi=5, lo=0xFFFFFFFF.
- Start DIVU 100/7. During busy: pulse start with new operands and pulse hi_wen with wdat=0xDEADBEEF -> both ignored; result lo=14, hi=2. Then in IDLE, lo_wen with wdat=0x12345678 -> lo=0x12345678 next cycle, hi unchanged.
- Start MULTU 0x10000*0x10000; assert nrst at iteration 10 -> busy=0, done never pulses, hi=lo=0. A fresh start afterwards completes normally: hi=1, lo=0.
